// File: rtl/can_pkg.sv
// Shared CAN definitions: FSM encoding, field widths and CRC-15 polynomial.
// Intended to be imported by both the transmitter and the receiver.
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_CRC,
    ST_TAIL,
    ST_DONE
  } state_t;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int ID_A_W    = 11;
  localparam int ID_B_W    = 18;
  localparam int DLC_W     = 4;
  localparam int MAX_BYTES = 8;
  localparam int EOF_BITS  = 7;
  localparam int IFS_BITS  = 3;
  localparam int CRC_W     = 15;

  // SOF, Id_A, RTR, IDE, r0, DLC  /  SOF, Id_A, SRR, IDE, Id_B, RTR, r1, r0, DLC
  localparam int HDR_STD_BITS = 1 + ID_A_W + 3 + DLC_W;
  localparam int HDR_EXT_BITS = 1 + ID_A_W + 2 + ID_B_W + 3 + DLC_W;
  // CRC delimiter, ACK slot, ACK delimiter, EOF, intermission
  localparam int TAIL_BITS    = 3 + EOF_BITS + IFS_BITS;

  // Number of data-field bits: remote frames carry none, DLC above 8 saturates.
  function automatic logic [6:0] data_bits(input logic rtr, input logic [DLC_W-1:0] dlc);
    if (rtr) begin
      return 7'd0;
    end else if (dlc > 4'(MAX_BYTES)) begin
      return 7'(MAX_BYTES * 8);
    end else begin
      return {dlc, 3'b000};
    end
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator, one bit per enabled cycle; result visible the cycle after.
// No backpressure: clear has priority over enable.
module can_crc15
  import can_pkg::*;
(
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Clear,
  input  logic              i_Enable,
  input  logic              i_Bit,
  output logic [CRC_W-1:0]  o_Crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = i_Bit ^ r_crc[CRC_W-1];
  assign o_Crc = r_crc;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      r_crc <= '0;
    end else if (i_Enable) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC15_POLY : 15'h0000);
    end
  end

endmodule

// File: rtl/can_tx.sv
// Bit-serial CAN 2.0 frame transmitter (no stuffing); SOF leaves one cycle after the accepted request.
// No backpressure: requests arriving while a frame is in flight are dropped.
module can_tx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Tx_DV,
  input  logic                i_IDE,
  input  logic                i_RTR,
  input  logic [ID_A_W-1:0]   i_Id_A,
  input  logic [ID_B_W-1:0]   i_Id_B,
  input  logic [DLC_W-1:0]    i_DLC,
  input  logic [63:0]         i_Data,
  output logic                o_Tx_Serial,
  output logic                o_Tx_Active,
  output logic                o_Tx_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t               r_state;
  state_t               w_next;

  logic [CNT_W-1:0]     r_clk_cnt;
  logic [6:0]           r_bit_cnt;
  logic [HDR_EXT_BITS-1:0] r_hdr;
  logic [63:0]          r_data;
  logic                 r_ide;
  logic [6:0]           r_nbits;
  logic                 r_serial;
  logic                 r_active;

  logic [CRC_W-1:0]     w_crc;
  logic [3:0]           w_crc_idx;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_bit_end;
  logic                 w_field_end;
  logic [6:0]           w_field_len;
  logic                 w_bit;
  logic                 w_crc_en;
  logic                 w_tx_done;

  assign w_accept  = (r_state == ST_IDLE) && i_Tx_DV;
  assign w_busy    = r_state inside {ST_HEADER, ST_DATA, ST_CRC, ST_TAIL};
  assign w_bit_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_crc_idx = 4'd14 - r_bit_cnt[3:0];

  can_crc15 u_crc (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (w_accept),
    .i_Enable (w_crc_en),
    .i_Bit    (w_bit),
    .o_Crc    (w_crc)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // w_bit is the bit the FSM is currently on; the registered copy on the pin lags it by one cycle.
  always_comb begin
    w_next      = r_state;
    w_bit       = 1'b1;
    w_field_len = 7'd1;
    w_crc_en    = 1'b0;
    w_tx_done   = 1'b0;
    w_field_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_Tx_DV) w_next = ST_HEADER;
      end
      ST_HEADER: begin
        w_bit       = r_hdr[HDR_EXT_BITS-1];
        w_field_len = r_ide ? 7'(HDR_EXT_BITS) : 7'(HDR_STD_BITS);
        w_crc_en    = w_bit_end;
        w_field_end = w_bit_end && (r_bit_cnt == w_field_len - 7'd1);
        if (w_field_end) w_next = (r_nbits != 7'd0) ? ST_DATA : ST_CRC;
      end
      ST_DATA: begin
        w_bit       = r_data[63];
        w_field_len = r_nbits;
        w_crc_en    = w_bit_end;
        w_field_end = w_bit_end && (r_bit_cnt == w_field_len - 7'd1);
        if (w_field_end) w_next = ST_CRC;
      end
      ST_CRC: begin
        w_bit       = w_crc[w_crc_idx];
        w_field_len = 7'(CRC_W);
        w_field_end = w_bit_end && (r_bit_cnt == w_field_len - 7'd1);
        if (w_field_end) w_next = ST_TAIL;
      end
      ST_TAIL: begin
        w_bit       = 1'b1;
        w_field_len = 7'(TAIL_BITS);
        w_field_end = w_bit_end && (r_bit_cnt == w_field_len - 7'd1);
        if (w_field_end) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_tx_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_hdr     <= '0;
      r_data    <= '0;
      r_ide     <= 1'b0;
      r_nbits   <= '0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
    end else begin
      r_serial <= w_bit;
      r_active <= w_busy && (w_next != ST_DONE);
      if (w_accept) begin
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
        r_ide     <= i_IDE;
        r_nbits   <= data_bits(i_RTR, i_DLC);
        r_data    <= i_Data;
        // Header is left-aligned so both formats shift out of the same MSB.
        if (i_IDE) begin
          r_hdr <= {1'b0, i_Id_A, 1'b1, 1'b1, i_Id_B, i_RTR, 2'b00, i_DLC};
        end else begin
          r_hdr <= {1'b0, i_Id_A, i_RTR, 2'b00, i_DLC,
                    {(HDR_EXT_BITS - HDR_STD_BITS){1'b0}}};
        end
      end else if (w_busy) begin
        if (w_bit_end) begin
          r_clk_cnt <= '0;
          r_bit_cnt <= w_field_end ? 7'd0 : r_bit_cnt + 7'd1;
          if (r_state == ST_HEADER) r_hdr  <= {r_hdr[HDR_EXT_BITS-2:0], 1'b0};
          if (r_state == ST_DATA)   r_data <= {r_data[62:0], 1'b0};
        end else begin
          r_clk_cnt <= r_clk_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Done   = w_tx_done;

endmodule

// File: tb/tb_can_tx.sv
// Directed bench for can_tx: frame bits against a reference frame builder, timing and control cases.
module tb_can_tx;

  localparam int C = 10;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic        i_Tx_DV;
  logic        i_IDE;
  logic        i_RTR;
  logic [10:0] i_Id_A;
  logic [17:0] i_Id_B;
  logic [3:0]  i_DLC;
  logic [63:0] i_Data;
  logic        o_Tx_Serial;
  logic        o_Tx_Active;
  logic        o_Tx_Done;

  int checks_total = 0;
  int checks_pass  = 0;

  logic exp_q[$];
  logic cap_bits[0:255];

  always #5 clk = ~clk;

  can_tx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Tx_DV     (i_Tx_DV),
    .i_IDE       (i_IDE),
    .i_RTR       (i_RTR),
    .i_Id_A      (i_Id_A),
    .i_Id_B      (i_Id_B),
    .i_DLC       (i_DLC),
    .i_Data      (i_Data),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Done   (o_Tx_Done)
  );

  // Reference frame builder: fills exp_q with every bit up to the end of EOF.
  task automatic build_frame(input logic ide, input logic rtr, input logic [10:0] ida,
                             input logic [17:0] idb, input logic [3:0] dlc, input logic [63:0] data);
    logic [14:0] crc;
    logic        fb;
    int          n;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) exp_q.push_back(ida[i]);
    if (ide) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      for (int i = 17; i >= 0; i--) exp_q.push_back(idb[i]);
      exp_q.push_back(rtr);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
    end else begin
      exp_q.push_back(rtr);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) exp_q.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < 8 * n; i++) exp_q.push_back(data[63 - i]);
    crc = 15'h0;
    for (int i = 0; i < exp_q.size(); i++) begin
      fb  = exp_q[i] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0);
    end
    for (int i = 14; i >= 0; i--) exp_q.push_back(crc[i]);
    for (int i = 0; i < 10; i++) exp_q.push_back(1'b1);
  endtask

  function automatic logic [63:0] cap_field(input int start, input int len);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[62:0], cap_bits[start + i]};
    return v;
  endfunction

  // Sends one frame and checks every cycle of it; disturb_at >= 1 injects a request and input changes mid-frame.
  task automatic run_frame(input string name, input logic ide, input logic rtr, input logic [10:0] ida,
                           input logic [17:0] idb, input logic [3:0] dlc, input logic [63:0] data,
                           input int exp_done, input int disturb_at);
    int  len, span, bit_err, act_err, done_cnt, done_at, first_bad;
    logic exp_ser, exp_act;
    build_frame(ide, rtr, ida, idb, dlc, data);
    len = exp_q.size();
    span = (len + 3) * C;
    bit_err = 0; act_err = 0; done_cnt = 0; done_at = -1; first_bad = -1;
    for (int j = 0; j < 256; j++) cap_bits[j] = 1'bx;
    @(negedge clk);
    i_IDE = ide; i_RTR = rtr; i_Id_A = ida; i_Id_B = idb; i_DLC = dlc; i_Data = data;
    i_Tx_DV = 1'b1;
    @(posedge clk);
    #1 i_Tx_DV = 1'b0;
    for (int m = 1; m <= span + 3 * C; m++) begin
      if (m == disturb_at) begin
        i_Tx_DV = 1'b1; i_Id_A = ~ida; i_IDE = ~ide; i_DLC = 4'd8; i_Data = ~data;
      end else if (m == disturb_at + 1) begin
        i_Tx_DV = 1'b0;
      end
      @(posedge clk);
      #1;
      exp_ser = (m <= len * C) ? exp_q[(m - 1) / C] : 1'b1;
      exp_act = (m < span);
      if (o_Tx_Serial !== exp_ser) begin
        bit_err++;
        if (first_bad < 0) first_bad = m;
      end
      if (o_Tx_Active !== exp_act) act_err++;
      if (o_Tx_Done === 1'b1) begin
        done_cnt++;
        done_at = m;
      end
      if ((m % C) == (C / 2) && (m / C) < 256) cap_bits[m / C] = o_Tx_Serial;
    end
    checks_total++;
    if (bit_err !== 0)
      $display("FAIL %s.serial: %0d wrong cycles, first at cycle %0d, expected 0", name, bit_err, first_bad);
    else checks_pass++;
    checks_total++;
    if (act_err !== 0) $display("FAIL %s.active: %0d wrong cycles, expected 0", name, act_err);
    else checks_pass++;
    checks_total++;
    if (done_cnt !== 1) $display("FAIL %s.done_count: got %0d expected 1", name, done_cnt);
    else checks_pass++;
    checks_total++;
    if (done_at !== exp_done) $display("FAIL %s.done_cycle: got %0d expected %0d", name, done_at, exp_done);
    else checks_pass++;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Tx_DV = 1'b0; i_IDE = 1'b0; i_RTR = 1'b0;
    i_Id_A = '0; i_Id_B = '0; i_DLC = '0; i_Data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (o_Tx_Serial !== 1'b1) $display("FAIL reset.serial: got %b expected 1", o_Tx_Serial);
    else checks_pass++;
    checks_total++;
    if (o_Tx_Active !== 1'b0) $display("FAIL reset.active: got %b expected 0", o_Tx_Active);
    else checks_pass++;
    checks_total++;
    if (o_Tx_Done !== 1'b0) $display("FAIL reset.done: got %b expected 0", o_Tx_Done);
    else checks_pass++;
    @(negedge clk);
    i_Reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_std_data();
    run_frame("std_data", 1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hA500_0000_0000_0000, 550, -1);
    checks_total++;
    if (cap_field(1, 11) !== 64'h123) $display("FAIL std_data.id: got %h expected 123", cap_field(1, 11));
    else checks_pass++;
    checks_total++;
    if (cap_field(19, 8) !== 64'hA5) $display("FAIL std_data.byte0: got %h expected a5", cap_field(19, 8));
    else checks_pass++;
  endtask

  task automatic test_ext_remote();
    run_frame("ext_remote", 1'b1, 1'b1, 11'h7FF, 18'h3FFFF, 4'd4, 64'hDEAD_BEEF_0000_0000, 670, -1);
    checks_total++;
    if ({cap_bits[12], cap_bits[13], cap_bits[32]} !== 3'b111)
      $display("FAIL ext_remote.srr_ide_rtr: got %b%b%b expected 111", cap_bits[12], cap_bits[13], cap_bits[32]);
    else checks_pass++;
    checks_total++;
    if (cap_field(35, 4) !== 64'h4) $display("FAIL ext_remote.dlc: got %h expected 4", cap_field(35, 4));
    else checks_pass++;
  endtask

  task automatic test_dlc0();
    run_frame("dlc0", 1'b0, 1'b0, 11'h0AA, 18'h0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 470, -1);
  endtask

  task automatic test_dlc12();
    run_frame("dlc12", 1'b0, 1'b0, 11'h321, 18'h0, 4'd12, 64'h0123_4567_89AB_CDEF, 1110, -1);
    checks_total++;
    if (cap_field(15, 4) !== 64'hC) $display("FAIL dlc12.dlc_bits: got %h expected c", cap_field(15, 4));
    else checks_pass++;
    checks_total++;
    if (cap_field(19, 64) !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL dlc12.data: got %h expected 0123456789abcdef", cap_field(19, 64));
    else checks_pass++;
  endtask

  task automatic test_mid_frame_request();
    run_frame("mid_req", 1'b0, 1'b0, 11'h123, 18'h0, 4'd2, 64'h1234_0000_0000_0000, 630, 100);
  endtask

  task automatic test_reset_mid_frame();
    int done_seen, ser_err;
    @(negedge clk);
    i_IDE = 1'b0; i_RTR = 1'b0; i_Id_A = 11'h123; i_Id_B = '0; i_DLC = 4'd1;
    i_Data = 64'hA500_0000_0000_0000; i_Tx_DV = 1'b1;
    @(posedge clk);
    #1 i_Tx_DV = 1'b0;
    repeat (20 * C + 3) @(posedge clk);
    #1 i_Reset = 1'b1;
    @(posedge clk);
    #1;
    checks_total++;
    if (o_Tx_Serial !== 1'b1) $display("FAIL rst_mid.serial: got %b expected 1", o_Tx_Serial);
    else checks_pass++;
    checks_total++;
    if (o_Tx_Active !== 1'b0) $display("FAIL rst_mid.active: got %b expected 0", o_Tx_Active);
    else checks_pass++;
    i_Reset = 1'b0;
    done_seen = 0; ser_err = 0;
    for (int m = 0; m < 600; m++) begin
      @(posedge clk);
      #1;
      if (o_Tx_Done === 1'b1) done_seen++;
      if (o_Tx_Serial !== 1'b1) ser_err++;
    end
    checks_total++;
    if (done_seen !== 0 || ser_err !== 0)
      $display("FAIL rst_mid.quiet: got %0d done pulses, %0d non-idle cycles, expected 0 and 0", done_seen, ser_err);
    else checks_pass++;
    run_frame("rst_recover", 1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hA500_0000_0000_0000, 550, -1);
  endtask

  task automatic test_loopback_decode();
    run_frame("loopback", 1'b0, 1'b0, 11'h555, 18'h0, 4'd2, 64'hBEEF_0000_0000_0000, 630, -1);
    checks_total++;
    if (cap_field(1, 11) !== 64'h555) $display("FAIL loopback.id: got %h expected 555", cap_field(1, 11));
    else checks_pass++;
    checks_total++;
    if ({cap_bits[12], cap_bits[13]} !== 2'b00)
      $display("FAIL loopback.rtr_ide: got %b%b expected 00", cap_bits[12], cap_bits[13]);
    else checks_pass++;
    checks_total++;
    if (cap_field(15, 4) !== 64'h2) $display("FAIL loopback.dlc: got %h expected 2", cap_field(15, 4));
    else checks_pass++;
    checks_total++;
    if (cap_field(19, 16) !== 64'hBEEF) $display("FAIL loopback.data: got %h expected beef", cap_field(19, 16));
    else checks_pass++;
  endtask

  initial begin
    test_reset();
    test_std_data();
    test_ext_remote();
    test_dlc0();
    test_dlc12();
    test_mid_frame_request();
    test_reset_mid_frame();
    test_loopback_decode();
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
